// File: rtl/i2s_line_in_rx_if.sv
// Codec serial-port lines plus the parallel stereo sample bus of the line-in receiver.
// DATA_WIDTH must match the receiver instance that uses the slave modport.
interface i2s_line_in_rx_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  i2s_bclk;
  logic                  i2s_lrclk;
  logic                  i2s_sdata;
  logic [DATA_WIDTH-1:0] left_sample;
  logic [DATA_WIDTH-1:0] right_sample;
  logic                  sample_valid;
  logic                  frame_error;
  logic                  locked;

  // Receiver side: consumes the codec lines, produces samples and status.
  modport slave (
    input  i2s_bclk,
    input  i2s_lrclk,
    input  i2s_sdata,
    output left_sample,
    output right_sample,
    output sample_valid,
    output frame_error,
    output locked
  );

  // Codec/consumer side: drives the serial lines, observes samples and status.
  modport master (
    output i2s_bclk,
    output i2s_lrclk,
    output i2s_sdata,
    input  left_sample,
    input  right_sample,
    input  sample_valid,
    input  frame_error,
    input  locked
  );
endinterface

// File: rtl/i2s_line_in_rx.sv
// I2S capture receiver: oversamples the codec bit clock, deserializes left/right slots
// MSB-first and presents each complete stereo frame with a one-cycle sample_valid strobe.
module i2s_line_in_rx #(
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  i2s_line_in_rx_if.slave rx
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  logic bclk_s1_q, bclk_s1_d;
  logic bclk_s2_q, bclk_s2_d;
  logic bclk_s3_q, bclk_s3_d;
  logic lrclk_s1_q, lrclk_s1_d;
  logic lrclk_s2_q, lrclk_s2_d;
  logic sdata_s1_q, sdata_s1_d;
  logic sdata_s2_q, sdata_s2_d;

  state_t                state_q, state_d;
  logic                  prev_lr_q, prev_lr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  left_ok_q, left_ok_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;

  logic [DATA_WIDTH-1:0] left_sample_q, left_sample_d;
  logic [DATA_WIDTH-1:0] right_sample_q, right_sample_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  frame_error_q, frame_error_d;
  logic                  locked_q, locked_d;

  logic bclk_rise;
  logic wd_expire;
  logic rise_ok;
  logic boundary;
  logic slot_full;

  always_comb begin
    bclk_s1_d  = rx.i2s_bclk;
    bclk_s2_d  = bclk_s1_q;
    bclk_s3_d  = bclk_s2_q;
    lrclk_s1_d = rx.i2s_lrclk;
    lrclk_s2_d = lrclk_s1_q;
    sdata_s1_d = rx.i2s_sdata;
    sdata_s2_d = sdata_s1_q;

    bclk_rise = bclk_s2_q & ~bclk_s3_q;
    wd_expire = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
    // A rise landing on the expiry cycle is dropped so the timeout wins cleanly.
    rise_ok   = bclk_rise & ~wd_expire;
    boundary  = rise_ok & (lrclk_s2_q != prev_lr_q);
    slot_full = (bit_cnt_q == CNT_W'(DATA_WIDTH));

    state_d        = state_q;
    prev_lr_d      = prev_lr_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    left_hold_d    = left_hold_q;
    left_ok_d      = left_ok_q;
    left_sample_d  = left_sample_q;
    right_sample_d = right_sample_q;
    sample_valid_d = 1'b0;
    frame_error_d  = 1'b0;
    locked_d       = locked_q;

    // Saturating one past the threshold makes the expiry a single-cycle event.
    if (bclk_rise) begin
      wdog_d = '0;
    end else if (wdog_q != WD_W'(TIMEOUT_CYCLES)) begin
      wdog_d = wdog_q + WD_W'(1);
    end else begin
      wdog_d = wdog_q;
    end

    if (wd_expire) begin
      state_d       = SYNC;
      locked_d      = 1'b0;
      left_ok_d     = 1'b0;
      bit_cnt_d     = '0;
      frame_error_d = (state_q != SYNC);
    end else if (rise_ok) begin
      prev_lr_d = lrclk_s2_q;
      // The bit on a boundary rise is the previous slot's LSB (one-bit delay).
      if (boundary) begin
        bit_cnt_d = '0;
      end else if (!slot_full) begin
        shift_d   = {shift_q[DATA_WIDTH-2:0], sdata_s2_q};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end

      if (boundary) begin
        case (state_q)
          SYNC: begin
            if (!lrclk_s2_q) begin
              state_d = LEFT;
            end
          end
          LEFT: begin
            if (lrclk_s2_q) begin
              state_d   = RIGHT;
              left_ok_d = slot_full;
              if (slot_full) begin
                left_hold_d = shift_q;
                locked_d    = 1'b1;
              end
            end
          end
          RIGHT: begin
            if (!lrclk_s2_q) begin
              state_d = LEFT;
              if (slot_full && left_ok_q) begin
                left_sample_d  = left_hold_q;
                right_sample_d = shift_q;
                sample_valid_d = 1'b1;
              end else begin
                frame_error_d = 1'b1;
              end
            end
          end
          default: begin
            state_d = SYNC;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1_q      <= 1'b0;
      bclk_s2_q      <= 1'b0;
      bclk_s3_q      <= 1'b0;
      lrclk_s1_q     <= 1'b0;
      lrclk_s2_q     <= 1'b0;
      sdata_s1_q     <= 1'b0;
      sdata_s2_q     <= 1'b0;
      state_q        <= SYNC;
      prev_lr_q      <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      left_hold_q    <= '0;
      left_ok_q      <= 1'b0;
      wdog_q         <= '0;
      left_sample_q  <= '0;
      right_sample_q <= '0;
      sample_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      bclk_s1_q      <= bclk_s1_d;
      bclk_s2_q      <= bclk_s2_d;
      bclk_s3_q      <= bclk_s3_d;
      lrclk_s1_q     <= lrclk_s1_d;
      lrclk_s2_q     <= lrclk_s2_d;
      sdata_s1_q     <= sdata_s1_d;
      sdata_s2_q     <= sdata_s2_d;
      state_q        <= state_d;
      prev_lr_q      <= prev_lr_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      left_hold_q    <= left_hold_d;
      left_ok_q      <= left_ok_d;
      wdog_q         <= wdog_d;
      left_sample_q  <= left_sample_d;
      right_sample_q <= right_sample_d;
      sample_valid_q <= sample_valid_d;
      frame_error_q  <= frame_error_d;
      locked_q       <= locked_d;
    end
  end

  assign rx.left_sample  = left_sample_q;
  assign rx.right_sample = right_sample_q;
  assign rx.sample_valid = sample_valid_q;
  assign rx.frame_error  = frame_error_q;
  assign rx.locked       = locked_q;

endmodule

// File: tb/tb_i2s_line_in_rx.sv
// Directed bench for i2s_line_in_rx: a slot-level frame model predicts every strobe,
// and a per-cycle compare process checks strobes, latency and output stability.
module tb_i2s_line_in_rx;

  localparam int DW = 24;
  localparam int TO = 1024;
  localparam int H  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2s_line_in_rx_if #(.DATA_WIDTH(DW)) bus ();

  i2s_line_in_rx #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rx     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            t0;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] cur_l = '0;
  logic [DW-1:0] cur_r = '0;

  bit            m_synced   = 1'b0;
  bit            m_left_ok  = 1'b0;
  logic          m_prev_lr  = 1'b0;
  logic [DW-1:0] m_hold     = '0;
  logic [DW-1:0] m_last_w   = '0;
  int            m_last_n   = 0;
  int            last_rise  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Slot-level model: a slot is complete when it lasts at least DW+1 bit periods.
  task automatic model_boundary(input logic lr);
    bit  complete;
    ev_t e;
    complete = (m_last_n >= DW + 1);
    if (lr != m_prev_lr) begin
      if (!m_synced) begin
        if (!lr) m_synced = 1'b1;
      end else if (lr) begin
        m_left_ok = complete;
        if (complete) m_hold = m_last_w;
      end else begin
        e.is_err = !(complete && m_left_ok);
        e.l      = m_hold;
        e.r      = m_last_w;
        e.t0     = last_rise;
        exp_q.push_back(e);
        $display("frame closed at cycle %0d: expect %s L=%06h R=%06h", cyc,
                 e.is_err ? "frame_error" : "sample_valid", e.l, e.r);
      end
    end
    m_prev_lr = lr;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_left_sample",  32'(bus.left_sample),  32'h0);
    chk("rst_right_sample", 32'(bus.right_sample), 32'h0);
    chk("rst_sample_valid", 32'(bus.sample_valid), 32'h0);
    chk("rst_frame_error",  32'(bus.frame_error),  32'h0);
    chk("rst_locked",       32'(bus.locked),       32'h0);
    m_synced  = 1'b0;
    m_left_ok = 1'b0;
    m_prev_lr = 1'b0;
    cur_l     = '0;
    cur_r     = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One slot of nper bclk periods; data changes on the falling bclk edge.
  task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int nper,
                           input int reset_at = -1);
    for (int k = 0; k < nper; k++) begin
      bus.i2s_bclk  = 1'b0;
      bus.i2s_lrclk = lr;
      bus.i2s_sdata = (k >= 1 && k <= DW) ? w[DW-k] : 1'b1;
      if (k == reset_at) do_reset();
      repeat (H) @(negedge clk);
      bus.i2s_bclk = 1'b1;
      last_rise    = cyc;
      if (k == 0) model_boundary(lr);
      repeat (H) @(negedge clk);
    end
    m_last_w = w;
    m_last_n = nper;
  endtask

  task automatic stop_bclk(input int ncyc);
    ev_t e;
    int  t;
    t = last_rise;
    if (m_synced) begin
      e.is_err = 1'b1;
      e.l      = '0;
      e.r      = '0;
      e.t0     = t + TO - 1;
      exp_q.push_back(e);
      $display("bclk stopped at cycle %0d: expect timeout frame_error", t);
    end
    m_synced  = 1'b0;
    m_left_ok = 1'b0;
    while (cyc < t + TO - 4) @(negedge clk);
    chk("locked_before_timeout", 32'(bus.locked), 32'h1);
    while (cyc < t + TO + 6) @(negedge clk);
    chk("locked_after_timeout", 32'(bus.locked), 32'h0);
    while (cyc < t + ncyc) @(negedge clk);
  endtask

  // Compare process: every strobe must match the next predicted event within 2..6 cycles.
  always @(negedge clk) begin
    ev_t e;
    chk("strobe_exclusive", 32'(bus.sample_valid & bus.frame_error), 32'h0);
    while (exp_q.size() > 0 && (cyc - exp_q[0].t0) > 6) begin
      chk("strobe_deadline", 32'(cyc - exp_q[0].t0), 32'd6);
      void'(exp_q.pop_front());
    end
    if (bus.sample_valid || bus.frame_error) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, bus.sample_valid, bus.frame_error}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind_is_err", 32'(bus.frame_error), 32'(e.is_err));
        chk("strobe_latency_in_window",
            32'((cyc - e.t0) >= 2 && (cyc - e.t0) <= 6), 32'h1);
        if (!e.is_err) begin
          chk("valid_left",  32'(bus.left_sample),  32'(e.l));
          chk("valid_right", 32'(bus.right_sample), 32'(e.r));
          cur_l = e.l;
          cur_r = e.r;
        end
        $display("strobe at cycle %0d: %s L=%06h R=%06h", cyc,
                 bus.frame_error ? "frame_error" : "sample_valid",
                 bus.left_sample, bus.right_sample);
      end
    end
    if (!bus.sample_valid) begin
      chk("left_stable",  32'(bus.left_sample),  32'(cur_l));
      chk("right_stable", 32'(bus.right_sample), 32'(cur_r));
    end
  end

  initial begin
    bus.i2s_bclk  = 1'b0;
    bus.i2s_lrclk = 1'b0;
    bus.i2s_sdata = 1'b0;
    repeat (4) @(negedge clk);
    chk("init_left_sample",  32'(bus.left_sample),  32'h0);
    chk("init_right_sample", 32'(bus.right_sample), 32'h0);
    chk("init_sample_valid", 32'(bus.sample_valid), 32'h0);
    chk("init_frame_error",  32'(bus.frame_error),  32'h0);
    chk("init_locked",       32'(bus.locked),       32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Start mid-right slot, then nominal frames.
    send_slot(1'b1, 24'h000000, 10);
    chk("locked_mid_right", 32'(bus.locked), 32'h0);
    send_slot(1'b0, 24'h123456, 32);
    chk("locked_after_sync", 32'(bus.locked), 32'h0);
    send_slot(1'b1, 24'hABCDEF, 32);
    chk("locked_after_left", 32'(bus.locked), 32'h1);
    send_slot(1'b0, 24'h800000, 32);
    chk("nominal_left",  32'(bus.left_sample),  32'h123456);
    chk("nominal_right", 32'(bus.right_sample), 32'hABCDEF);
    send_slot(1'b1, 24'h7FFFFF, 32);
    send_slot(1'b0, 24'h0F0F0F, 32);
    chk("second_left",  32'(bus.left_sample),  32'h800000);
    chk("second_right", 32'(bus.right_sample), 32'h7FFFFF);
    send_slot(1'b1, 24'hF0F0F0, 32);

    // Short right slot.
    send_slot(1'b0, 24'h111111, 32);
    send_slot(1'b1, 24'h222222, 20);
    send_slot(1'b0, 24'h333333, 32);
    chk("short_hold_left",  32'(bus.left_sample),  32'h0F0F0F);
    chk("short_hold_right", 32'(bus.right_sample), 32'hF0F0F0);
    send_slot(1'b1, 24'h444444, 32);

    // Exact-length slots: 25 periods accepted, 24 rejected.
    send_slot(1'b0, 24'h555555, 25);
    chk("after_short_left",  32'(bus.left_sample),  32'h333333);
    chk("after_short_right", 32'(bus.right_sample), 32'h444444);
    send_slot(1'b1, 24'h666666, 25);
    send_slot(1'b0, 24'h777777, 25);
    chk("exact_left",  32'(bus.left_sample),  32'h555555);
    chk("exact_right", 32'(bus.right_sample), 32'h666666);
    send_slot(1'b1, 24'h888888, 24);
    send_slot(1'b0, 24'h999999, 32);
    chk("one_short_hold_left", 32'(bus.left_sample), 32'h555555);
    send_slot(1'b1, 24'hAAAAAA, 32);

    // Bit-clock loss and recovery.
    stop_bclk(1100);
    chk("loss_hold_right", 32'(bus.right_sample), 32'h666666);
    send_slot(1'b0, 24'hC0FFEE, 32);
    send_slot(1'b1, 24'h0BEEF0, 32);
    chk("relocked", 32'(bus.locked), 32'h1);
    send_slot(1'b0, 24'h246802, 32);
    chk("relock_left",  32'(bus.left_sample),  32'hC0FFEE);
    chk("relock_right", 32'(bus.right_sample), 32'h0BEEF0);
    send_slot(1'b1, 24'h135791, 32);

    // Reset during a left slot, then resynchronize.
    send_slot(1'b0, 24'h2468AC, 32, 10);
    chk("post_reset_locked", 32'(bus.locked), 32'h0);
    send_slot(1'b1, 24'h111111, 32);
    send_slot(1'b0, 24'hABCDEF, 32);
    send_slot(1'b1, 24'h654321, 32);
    send_slot(1'b0, 24'h000000, 32);
    chk("post_reset_left",  32'(bus.left_sample),  32'hABCDEF);
    chk("post_reset_right", 32'(bus.right_sample), 32'h654321);

    repeat (20) @(negedge clk);
    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
